// File: rtl/mcycle_pkg.sv
// Shared definitions for the MCycle issuer: operation codes, FSM state encoding
// and a small operation-decode helper.
package mcycle_pkg;

  typedef enum logic [1:0] {
    MC_MUL_S = 2'b00,
    MC_MUL_U = 2'b01,
    MC_DIV_S = 2'b10,
    MC_DIV_U = 2'b11
  } mc_op_e;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  function automatic logic is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mcycle_watchdog.sv
// Saturating cycle counter that flags an MCycle operation running too long.
module mcycle_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  assign expired = (count == CW'(LIMIT));

  // Holds at LIMIT so expired stays asserted until the next clear.
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && !expired)
      count <= count + CW'(1);
  end

endmodule

// File: rtl/mcycle_issuer.sv
// Initiator for the MCycle Start/Busy protocol: takes one mul/div request,
// drives MCycle until Busy falls, and returns the captured result.
module mcycle_issuer
  import mcycle_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             Start,
  output logic [1:0]       MCycleOp,
  output logic [WIDTH-1:0] Operand1,
  output logic [WIDTH-1:0] Operand2,
  input  logic [WIDTH-1:0] Result1,
  input  logic [WIDTH-1:0] Result2,
  input  logic             Busy,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_lo,
  output logic [WIDTH-1:0] resp_hi,
  output logic             resp_err,
  output logic             stall
);

  logic [2:0] state;
  logic       expired;
  logic       wd_clear;
  logic       wd_en;

  assign req_ready = (state == S_IDLE);
  assign wd_clear  = (state == S_IDLE);
  assign wd_en     = (state == S_ISSUE) || (state == S_WAIT);

  mcycle_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (CLK),
    .rst     (RESET),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (expired)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      Start      <= 1'b0;
      MCycleOp   <= '0;
      Operand1   <= '0;
      Operand2   <= '0;
      resp_valid <= 1'b0;
      resp_lo    <= '0;
      resp_hi    <= '0;
      resp_err   <= 1'b0;
      stall      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            MCycleOp <= req_op;
            Operand1 <= req_a;
            Operand2 <= req_b;
            stall    <= 1'b1;
            // Divide-by-zero is answered locally; MCycle is never started.
            if (is_div(req_op) && (req_b == '0)) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_lo    <= '1;
              resp_hi    <= req_a;
              resp_err   <= 1'b1;
            end else begin
              state <= S_ISSUE;
              Start <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (Busy) begin
            state <= S_WAIT;
          end else if (expired) begin
            state      <= S_RESP;
            Start      <= 1'b0;
            resp_valid <= 1'b1;
            resp_lo    <= '0;
            resp_hi    <= '0;
            resp_err   <= 1'b1;
          end
        end
        S_WAIT: begin
          // A completed operation wins over a timeout landing on the same cycle.
          if (!Busy) begin
            state <= S_CAPTURE;
            Start <= 1'b0;
          end else if (expired) begin
            state      <= S_RESP;
            Start      <= 1'b0;
            resp_valid <= 1'b1;
            resp_lo    <= '0;
            resp_hi    <= '0;
            resp_err   <= 1'b1;
          end
        end
        S_CAPTURE: begin
          state      <= S_RESP;
          resp_lo    <= Result1;
          resp_hi    <= Result2;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            stall      <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          Start      <= 1'b0;
          resp_valid <= 1'b0;
          stall      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_issuer.sv
// Directed bench: mcycle_issuer driving a behavioural MCycle stub with
// configurable latency and a hang mode for the timeout path.
module tb_mcycle_issuer;

  localparam int W  = 4;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_a, req_b;
  logic         start;
  logic [1:0]   mc_op;
  logic [W-1:0] opnd1, opnd2;
  logic [W-1:0] res1, res2;
  logic         busy;
  logic         resp_valid, resp_ready;
  logic [W-1:0] resp_lo, resp_hi;
  logic         resp_err;
  logic         stall;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mcycle_issuer #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .CLK        (clk),
    .RESET      (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .Start      (start),
    .MCycleOp   (mc_op),
    .Operand1   (opnd1),
    .Operand2   (opnd2),
    .Result1    (res1),
    .Result2    (res2),
    .Busy       (busy),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_lo    (resp_lo),
    .resp_hi    (resp_hi),
    .resp_err   (resp_err),
    .stall      (stall)
  );

  // MCycle stub: starts on a rising Start, stays busy for lat+1 cycles.
  logic start_q;
  int   cnt;
  int   lat  = 3;
  logic hang = 1'b0;

  function automatic logic [2*W-1:0] mc_calc(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    int sa, sb, p, q, r;
    logic [31:0] pv, qv, rv;
    sa = op[0] ? int'(a) : int'($signed(a));
    sb = op[0] ? int'(b) : int'($signed(b));
    if (!op[1]) begin
      p  = sa * sb;
      pv = p;
      return pv[2*W-1:0];
    end
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[W-1:0], qv[W-1:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      start_q <= 1'b0;
      cnt     <= 0;
      res1    <= '0;
      res2    <= '0;
    end else begin
      start_q <= start;
      if (!busy && start && !start_q) begin
        busy <= 1'b1;
        cnt  <= lat;
      end else if (busy && !hang) begin
        if (cnt == 0) begin
          busy         <= 1'b0;
          {res2, res1} <= mc_calc(mc_op, opnd1, opnd2);
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    int n = 0;
    while (busy !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, lvl);
  endtask

  task automatic wait_resp(input string tag);
    int n = 0;
    while (resp_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, resp_valid, 1'b1);
  endtask

  // Present a request for one cycle; returns at the negedge after acceptance.
  task automatic send(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_stall"}, stall, 1'b1);
  endtask

  task automatic release_resp(input string tag);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, "_valid_drop"}, resp_valid, 1'b0);
    chk({tag, "_idle"}, req_ready, 1'b1);
    @(negedge clk);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] lo, input logic [W-1:0] hi);
    send(tag, op, a, b);
    chk({tag, "_start"}, start, 1'b1);
    wait_busy(1'b1, {tag, "_busy_rise"});
    wait_busy(1'b0, {tag, "_busy_fall"});
    chk({tag, "_start_held"}, start, 1'b1);
    @(negedge clk);
    chk({tag, "_start_drop"}, start, 1'b0);
    wait_resp({tag, "_resp"});
    chk({tag, "_lo"}, resp_lo, lo);
    chk({tag, "_hi"}, resp_hi, hi);
    chk({tag, "_err"}, resp_err, 1'b0);
    release_resp(tag);
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_start", start, 1'b0);
    chk("rst_op", mc_op, 2'b00);
    chk("rst_opnd", {opnd1, opnd2}, 8'h00);
    chk("rst_resp", {resp_valid, resp_lo, resp_hi, resp_err}, 10'h000);
    chk("rst_stall", stall, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    run_op("mul_s_ff", 2'b00, 4'hF, 4'hF, 4'h1, 4'h0);
    run_op("mul_u_ff", 2'b01, 4'hF, 4'hF, 4'h1, 4'hE);
    lat = 1;
    run_op("mul_s_7f", 2'b00, 4'h7, 4'hF, 4'h9, 4'hF);
    run_op("mul_u_7f", 2'b01, 4'h7, 4'hF, 4'h9, 4'h6);
    lat = 0;
    run_op("div_u_ff", 2'b11, 4'hF, 4'hF, 4'h1, 4'h0);
    lat = 5;
    run_op("div_s_7f", 2'b10, 4'h7, 4'hF, 4'h9, 4'h0);

    // Divide by zero: answered without ever starting MCycle.
    send("div0", 2'b11, 4'h7, 4'h0);
    chk("div0_resp_valid", resp_valid, 1'b1);
    chk("div0_start", start, 1'b0);
    chk("div0_lo", resp_lo, 4'hF);
    chk("div0_hi", resp_hi, 4'h7);
    chk("div0_err", resp_err, 1'b1);
    @(negedge clk);
    chk("div0_start_later", start, 1'b0);
    release_resp("div0");

    // Held response, ignored request, and operand isolation during WAIT.
    lat = 4;
    send("hold", 2'b01, 4'h3, 4'h5);
    wait_busy(1'b1, "hold_busy_rise");
    req_a  = 4'hA;
    req_b  = 4'hC;
    req_op = 2'b00;
    @(negedge clk);
    chk("hold_opnd1", opnd1, 4'h3);
    chk("hold_opnd2", opnd2, 4'h5);
    chk("hold_op", mc_op, 2'b01);
    wait_resp("hold_resp");
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", resp_valid, 1'b1);
      chk("hold_data", {resp_lo, resp_hi, resp_err}, {4'hF, 4'h0, 1'b0});
      chk("hold_req_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("hold_valid_drop", resp_valid, 1'b0);
    chk("hold_no_restart", {start, stall}, 2'b00);
    chk("hold_opnd1_kept", opnd1, 4'h3);
    @(negedge clk);

    // Timeout: stub never drops Busy.
    hang = 1'b1;
    send("tmo", 2'b01, 4'h3, 4'h5);
    n = 0;
    while (resp_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", n, TO + 1);
    chk("tmo_start", start, 1'b0);
    chk("tmo_data", {resp_lo, resp_hi}, 8'h00);
    chk("tmo_err", resp_err, 1'b1);
    release_resp("tmo");
    hang = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    @(negedge clk);

    // Reset in the middle of WAIT.
    lat = 10;
    send("rstw", 2'b00, 4'h2, 4'h3);
    wait_busy(1'b1, "rstw_busy_rise");
    @(negedge clk);
    chk("rstw_in_wait", start, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_start", start, 1'b0);
    chk("rstw_stall", stall, 1'b0);
    chk("rstw_req_ready", req_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    lat = 2;
    run_op("after_rst", 2'b01, 4'h2, 4'h3, 4'h6, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
